// File: rtl/ntt_sequencer.sv
// NTT sequencer: loads PE exponents, streams N coefficients into the systolic array, drains, then pulses done.
// Optional feature: define NTT_INVERSE_EN to add the inverse input, which selects (N-k) mod N exponents.
module ntt_sequencer #(
    parameter int N = 16,
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
`ifdef NTT_INVERSE_EN
    input  logic         inverse,
`endif
    input  logic         coef_valid,
    input  logic [W-1:0] coef_data,
    output logic         coef_ready,
    output logic         ArrayRst,
    output logic [31:0]  InternalRegisterEnableIndex,
    output logic [31:0]  InternalRegisterInputValue0,
    output logic [W-1:0] Dim0InputLane0,
    output logic [W-1:0] Dim0InputLane1,
    output logic         busy,
    output logic         done
);
    localparam int CW = $clog2(N) + 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [2:0] {IDLE, LOAD, STREAM, DRAIN, DONE} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] nextCnt;
    logic [31:0]   nextValue;

    assign nextCnt = cnt + CW'(1);

`ifdef NTT_INVERSE_EN
    logic invMode;
    // Masking with N-1 folds k=0 back to exponent 0 for the inverse ordering.
    always_comb nextValue = invMode ? 32'((CW'(N) - nextCnt) & LAST) : 32'(nextCnt);
`else
    always_comb nextValue = 32'(nextCnt);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state                       <= IDLE;
            cnt                         <= '0;
            ArrayRst                    <= 1'b1;
            busy                        <= 1'b0;
            done                        <= 1'b0;
            coef_ready                  <= 1'b0;
            InternalRegisterEnableIndex <= '0;
            InternalRegisterInputValue0 <= '0;
            Dim0InputLane0              <= '0;
            Dim0InputLane1              <= '0;
`ifdef NTT_INVERSE_EN
            invMode                     <= 1'b0;
`endif
        end else begin
            // Outputs below describe the cycle being entered, so each branch sets them for the next state.
            done                        <= 1'b0;
            ArrayRst                    <= 1'b0;
            InternalRegisterEnableIndex <= '0;
            InternalRegisterInputValue0 <= '0;
            Dim0InputLane0              <= '0;
            Dim0InputLane1              <= '0;
            case (state)
                IDLE: begin
                    busy       <= 1'b0;
                    coef_ready <= 1'b0;
                    if (start) begin
                        state                       <= LOAD;
                        cnt                         <= '0;
                        busy                        <= 1'b1;
                        ArrayRst                    <= 1'b1;
                        InternalRegisterEnableIndex <= 32'd1;
`ifdef NTT_INVERSE_EN
                        invMode                     <= inverse;
`endif
                    end
                end
                LOAD: begin
                    if (cnt == LAST) begin
                        state      <= STREAM;
                        cnt        <= '0;
                        coef_ready <= 1'b1;
                    end else begin
                        cnt                         <= nextCnt;
                        ArrayRst                    <= 1'b1;
                        InternalRegisterEnableIndex <= 32'(nextCnt) + 32'd1;
                        InternalRegisterInputValue0 <= nextValue;
                    end
                end
                STREAM: begin
                    if (coef_valid) begin
                        Dim0InputLane0 <= W'(cnt);
                        Dim0InputLane1 <= coef_data;
                        if (cnt == LAST) begin
                            state      <= DRAIN;
                            cnt        <= '0;
                            coef_ready <= 1'b0;
                        end else begin
                            cnt <= nextCnt;
                        end
                    end
                end
                DRAIN: begin
                    if (cnt == LAST) begin
                        state <= DONE;
                        cnt   <= '0;
                        done  <= 1'b1;
                    end else begin
                        cnt <= nextCnt;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state      <= IDLE;
                    cnt        <= '0;
                    busy       <= 1'b0;
                    coef_ready <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: doc/ntt_sequencer.md
NTT_SEQUENCER -- requirements
Module: ntt_sequencer

Interface
REQ-001 SHALL have parameter N, default 16, meaning NTT points / PE count, a power of two in 2..256.
REQ-002 SHALL have parameter W, default 32, meaning lane and coefficient width.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-005 SHALL have port start, input, 1 bit, a one-cycle request to run one transform; sampled only in IDLE.
REQ-006 SHALL have port coef_valid, input, 1 bit, coefficient offered.
REQ-007 SHALL have port coef_data, input, W bits, coefficient value.
REQ-008 SHALL have port coef_ready, output, 1 bit, coefficient accepted when high together with coef_valid.
REQ-009 SHALL have port ArrayRst, output, 1 bit, the systolic array rst.
REQ-010 SHALL have port InternalRegisterEnableIndex, output, 32 bits, PE select for the exponent load; PE k is loaded when the value is k+1; 0 loads none.
REQ-011 SHALL have port InternalRegisterInputValue0, output, 32 bits, exponent written to the selected PE.
REQ-012 SHALL have ports Dim0InputLane0 and Dim0InputLane1, output, W bits each, carrying sample index and coefficient.
REQ-013 SHALL have port busy, output, 1 bit, high in any state other than IDLE.
REQ-014 SHALL have port done, output, 1 bit, a one-cycle pulse when all PE accumulators hold final values.

Function
REQ-015 SHALL implement states IDLE, LOAD, STREAM, DRAIN and DONE, with all outputs registered.
REQ-016 IDLE SHALL drive ArrayRst=0, coef_ready=0, enable index 0 and lanes 0, so PE results are preserved; start=1 SHALL go to LOAD with counter k=0.
REQ-017 LOAD SHALL last exactly N cycles; in cycle k, ArrayRst=1, InternalRegisterEnableIndex=k+1 and InternalRegisterInputValue0=k; after k=N-1 the block SHALL go to STREAM.
REQ-018 STREAM SHALL drive ArrayRst=0 and coef_ready=1; a handshake in cycle t with count c SHALL put lanes = (c, coef_data) in cycle t+1, then increment c.
REQ-019 A no-handshake cycle in STREAM SHALL put lanes = (0, 0) in the next cycle; this is a bubble, harmless because the coefficient is 0.
REQ-020 The N-th handshake, at cycle t, SHALL move the block to DRAIN, with coef_ready=0 from cycle t+1.
REQ-021 DRAIN SHALL last N cycles (t+1..t+N) with lanes 0 after t+1; DONE SHALL occur at cycle t+N+1 with done=1 for exactly one cycle, then return to IDLE.
REQ-022 start outside IDLE SHALL be ignored; coef_valid outside STREAM SHALL be ignored; no coefficient is dropped or duplicated.
REQ-023 Counters SHALL be clog2(N)+1 bits wide; lane 0 values SHALL be zero-extended to W.

Reset
REQ-024 rst=1 SHALL force IDLE on the next edge with ArrayRst=1, busy=0, done=0, coef_ready=0, index 0, value 0, lanes 0 and counters 0.
REQ-025 ArrayRst SHALL return to 0 in the first cycle after rst deasserts.
REQ-026 rst SHALL take priority over start and over any in-flight run; reset mid-operation SHALL abandon the run without a done pulse.

Configuration
REQ-027 With NTT_INVERSE_EN defined, the block SHALL add input port inverse (1 bit), sampled with start; when it was 1, LOAD SHALL write (N-k) mod N to PE k.
REQ-028 Without NTT_INVERSE_EN, the inverse port SHALL be absent and LOAD SHALL always write k.

Verification
REQ-029 Reset, start, then coefficients 1..16 back-to-back (N=16) -> LOAD writes index 1..16 with values 0..15; lanes (0,1)..(15,16); done 17 cycles after the last handshake; PE0 accumulator = 136.
REQ-030 Same data with coef_valid low every other cycle -> lanes (0,0) on the bubble cycles; identical PE results; done still 17 cycles after the last handshake.
REQ-031 start pulsed during STREAM and during DRAIN -> no state change and exactly one done pulse.
REQ-032 rst asserted after 5 handshakes -> next cycle IDLE, ArrayRst=1, coef_ready=0, no done; a later start runs cleanly from k=0.
REQ-033 start and rst high in the same cycle -> block stays in IDLE and busy stays 0.
REQ-034 NTT_INVERSE_EN defined with inverse=1 -> LOAD values 0,15,14,...,1; with inverse=0 -> values 0..15.
